// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 16x oversampling, 2-of-3 majority voting per bit
// and a one-word holding register that reports parity, framing, break and overrun conditions.
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 sourceClk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun_err
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE} state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t               state, state_nxt;
    logic [1:0]           sync, primed;
    logic                 rx_s, rx_prev, fall;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick, smp, bit_end, maj, s7, s8;
    logic [3:0]           tcnt, bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, any_one, ferr, done_seen, first, load, par_bad;

    assign rx_s    = sync[1];
    assign fall    = rx_prev & ~rx_s;
    assign tick    = div_cnt >= baud_div;
    assign smp     = tick && tcnt == 4'd9;
    assign bit_end = tick && tcnt == 4'd15;
    assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign first   = state == ST_DONE && !done_seen;
    assign load    = first && (!rx_valid || rx_ready);
    assign par_bad = (PARITY != 0) && ((^shreg ^ par_bit) == (PARITY == 2));
    assign rx_busy = state != ST_IDLE;

    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = fall ? ST_START : ST_IDLE;
            ST_START:  state_nxt = (smp && maj) ? ST_IDLE : bit_end ? ST_DATA : ST_START;
            ST_DATA:   if (bit_end && bcnt == LAST_DATA) state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
            ST_STOP:   if (smp && bcnt == LAST_STOP) state_nxt = ST_DONE;
            ST_DONE:   if (any_one || rx_s) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // primed keeps the post-reset synchronizer contents from posing as a falling edge
    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            sync      <= 2'b11;
            primed    <= 2'b00;
            rx_prev   <= 1'b0;
            div_cnt   <= '0;
            tcnt      <= 4'd0;
            bcnt      <= 4'd0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            shreg     <= '0;
            par_bit   <= 1'b0;
            any_one   <= 1'b0;
            ferr      <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            sync      <= {sync[0], rx_in};
            primed    <= {primed[0], 1'b1};
            rx_prev   <= rx_s & primed[1];
            div_cnt   <= (state == ST_IDLE || tick) ? '0 : div_cnt + DIV_WIDTH'(1);
            tcnt      <= (state == ST_IDLE) ? 4'd0 : tick ? tcnt + 4'd1 : tcnt;
            bcnt      <= (state != state_nxt) ? 4'd0 : bit_end ? bcnt + 4'd1 : bcnt;
            done_seen <= state == ST_DONE;
            if (tick && tcnt == 4'd7) s7 <= rx_s;
            if (tick && tcnt == 4'd8) s8 <= rx_s;
            if (state == ST_IDLE) begin
                any_one <= 1'b0;
                ferr    <= 1'b0;
            end else if (smp && state == ST_DATA) begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                any_one <= any_one | maj;
            end else if (smp && state == ST_PARITY) begin
                par_bit <= maj;
                any_one <= any_one | maj;
            end else if (smp && state == ST_STOP) begin
                ferr    <= ferr | ~maj;
                any_one <= any_one | maj;
            end
        end
    end

    // a held, unaccepted word wins over a newly completed frame
    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= first && rx_valid && !rx_ready;
            rx_valid    <= load | (rx_valid & ~rx_ready);
            if (load) begin
                rx_data    <= shreg;
                frame_err  <= ferr;
                parity_err <= par_bad;
                break_det  <= ~any_one;
            end
        end
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame; legal values are 5 to 9.
REQ-002 The block SHALL have parameter PARITY, default 0, selecting the parity mode: 0 none, 1 odd, 2 even.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, giving the stop bits checked per frame; legal values are 1 and 2.
REQ-004 The block SHALL have parameter DIV_WIDTH, default 16, giving the width of the baud divisor.
REQ-005 The block SHALL have port sourceClk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port baud_div, input, DIV_WIDTH bits: the number of clocks per 1/16-bit tick, minus 1; it is sampled live.
REQ-009 The block SHALL have port rx_data, output, DATA_BITS bits: the received word, LSB received first.
REQ-010 The block SHALL have port rx_valid, output, 1 bit: rx_data and the error flags are valid.
REQ-011 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the word.
REQ-012 The block SHALL have port rx_busy, output, 1 bit: a frame is in progress.
REQ-013 The block SHALL have ports frame_err, parity_err and break_det, outputs, 1 bit each: status qualified by rx_valid.
REQ-014 The block SHALL have port overrun_err, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-015 rx_in SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-016 The tick generator SHALL assert a 1-cycle tick every baud_div+1 clocks.
REQ-017 The tick generator SHALL restart its count whenever the FSM leaves IDLE.
REQ-018 Each bit SHALL span 16 ticks.
REQ-019 Each bit value SHALL be the 2-of-3 majority of samples at ticks 7, 8 and 9.
REQ-020 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and DONE; rx_busy SHALL be high in every state except IDLE.
REQ-021 IDLE -> START SHALL occur on a synchronized falling edge.
REQ-022 START SHALL return to IDLE (false start, no output) when the start-bit majority is 1; otherwise START -> DATA.
REQ-023 DATA SHALL shift in DATA_BITS bits LSB first.
REQ-024 On DATA completion the FSM SHALL go to PARITY if PARITY != 0, else to STOP.
REQ-025 PARITY SHALL sample one bit and SHALL set parity_err when the XOR of data and parity bits mismatches the mode: odd requires XOR = 1, even requires XOR = 0.
REQ-026 STOP SHALL sample STOP_BITS bits and SHALL set frame_err if any sampled stop bit is 0.
REQ-027 STOP SHALL proceed to DONE at tick 9 of the last stop bit, not at the bit end.
REQ-028 break_det SHALL be set when all data bits, the parity bit if present, and the stop bits are 0.
REQ-029 After a break the FSM SHALL wait in DONE until the synchronized line is 1 before returning to IDLE.
REQ-030 In DONE, if rx_valid is 0 or rx_ready is 1 in that cycle, the block SHALL load rx_data and the flags and set rx_valid the next cycle.
REQ-031 In DONE, if rx_valid is 1 and rx_ready is 0, the block SHALL discard the new frame, keep the held word and flags, and pulse overrun_err.
REQ-032 rx_valid SHALL stay high until a cycle with rx_ready = 1, then SHALL clear the next cycle unless a simultaneous DONE load occurs (per REQ-030).
REQ-033 A load with simultaneous accept SHALL keep rx_valid high with the new word.
REQ-034 A baud_div change mid-frame SHALL take effect at the next tick boundary; no glitch protection is required.
REQ-035 baud_div = 0 SHALL yield a tick every clock.

Reset
REQ-036 Asserting reset low SHALL at once force IDLE, clear the tick counter, the synchronizer (to 1) and the shift register.
REQ-037 Asserting reset low SHALL at once set rx_data = 0, rx_valid = 0, rx_busy = 0 and all error flags = 0, including when reset occurs mid-frame.
REQ-038 After reset is released the block SHALL wait for a fresh falling edge; a line already low SHALL NOT start a frame.

Verification
REQ-039 Defaults, baud_div = 1 (32 clocks/bit), send 0xA5 8N1 -> rx_valid with rx_data = 0xA5, all flags 0; rx_valid holds until rx_ready.
REQ-040 Low glitch of 8 clocks on idle line -> false start, no rx_valid, rx_busy returns to 0.
REQ-041 PARITY = 2: send 0x03 with parity bit 1 -> parity_err = 1, rx_data = 0x03.
REQ-042 PARITY = 2: send 0x03 with parity bit 0 -> parity_err = 0, rx_data = 0x03.
REQ-043 Stop bit forced 0 -> frame_err = 1; line held low for 20 bit times -> break_det = 1, no further frame until the line returns high.
REQ-044 Send 0x11 then 0x22 back-to-back with rx_ready = 0 -> rx_data stays 0x11 and overrun_err pulses 1 cycle; with rx_ready = 1 in the DONE cycle instead -> 0x22 loaded, rx_valid stays high.
REQ-045 DATA_BITS = 5, STOP_BITS = 2, reset pulsed in bit 3 of a frame -> outputs zero at once; the next full frame 0x15 is received correctly.
